count_checker: RTL



---
 rtl/count_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/count_checker.sv
// count_checker: acquires lock on an incrementing counter stream, flags skips/jumps, and keeps saturating error and wrap statistics.
// Build option COUNT_CHECKER_HOLD_EN: in ACQ/TRACK a sample equal to expected-1 (stalled counter) is ignored.
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3,
  parameter int LOSS_LEN = 2,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              err_pulse,
  output logic [WIDTH-1:0]  expected,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] wrap_cnt
);

  // state | meaning
  // IDLE  | no sample seen since reset
  // ACQ   | counting consecutive correct increments toward lock
  // TRACK | locked; mismatches are errors, LOSS_LEN in a row drop lock
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]  CNT_ONES = '1;
  localparam logic [3:0]        LOCK_C   = 4'(LOCK_LEN);
  localparam logic [3:0]        LOSS_C   = 4'(LOSS_LEN);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic [3:0]        miss_q, miss_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
  logic [STAT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_pend_q, wrap_pend_d;

  logic [WIDTH-1:0]  cnt_inc;
  logic [3:0]        run_new;
  logic [3:0]        miss_inc;
  logic              match;
  logic              stall;

  assign cnt_inc  = count + CNT_ONE;
  assign match    = (count == exp_q);
  assign miss_inc = miss_q + 4'd1;

`ifdef COUNT_CHECKER_HOLD_EN
  logic [WIDTH-1:0] exp_m1;
  assign exp_m1 = exp_q - CNT_ONE;
  assign stall  = (state_q != IDLE) && (count == exp_m1);
`else
  assign stall  = 1'b0;
`endif

  // First sample and any ACQ reseed both restart the run at 1.
  assign run_new = (state_q == ACQ && match) ? (run_q + 4'd1) : 4'd1;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    miss_d      = miss_q;
    exp_d       = exp_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    wrap_pend_d = wrap_pend_q;
    if (valid && !stall) begin
      unique case (state_q)
        IDLE, ACQ: begin
          exp_d       = cnt_inc;
          run_d       = run_new;
          wrap_pend_d = 1'b0;
          if (run_new >= LOCK_C) begin
            state_d  = TRACK;
            locked_d = 1'b1;
            miss_d   = 4'd0;
          end else begin
            state_d  = ACQ;
          end
        end
        TRACK: begin
          exp_d = cnt_inc;
          if (match) begin
            miss_d      = 4'd0;
            wrap_pend_d = (count == CNT_ONES);
            if (wrap_pend_q && (count == '0) && (wrap_cnt_q != STAT_MAX)) begin
              wrap_cnt_d = wrap_cnt_q + STAT_ONE;
            end
          end else begin
            err_d       = 1'b1;
            wrap_pend_d = 1'b0;
            if (err_cnt_q != STAT_MAX) begin
              err_cnt_d = err_cnt_q + STAT_ONE;
            end
            if (miss_inc >= LOSS_C) begin
              state_d  = ACQ;
              locked_d = 1'b0;
              run_d    = 4'd1;
              miss_d   = 4'd0;
            end else begin
              miss_d   = miss_inc;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      exp_q       <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      wrap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      exp_q       <= exp_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_q;
  assign expected  = exp_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;

endmodule
